// File: rtl/syn_wm8731_i2c_cfg.sv
// WM8731 control-port I2C write master: walks a fixed register init table after
// reset, then issues single host-requested register writes.
module syn_wm8731_i2c_cfg #(
  parameter int unsigned QTR_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter bit          INIT_EN  = 1'b1
) (
  input  logic       clk_ir,
  input  logic       rst_il,
  input  logic       host_wr_en_i,
  input  logic [6:0] host_reg_i,
  input  logic [8:0] host_data_i,
  output logic       host_ready_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       nack_o,
  input  logic       nack_clr_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       release_sda_o,
  input  logic       sda_i
);
  localparam int unsigned QW = 12;
  localparam int unsigned SW = 5;
  localparam int unsigned FW = 27;
  localparam int unsigned IW = 4;
  localparam logic [QW-1:0] QTR_MAX   = QW'(QTR_DIV - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FW - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(10);

  typedef enum logic [2:0] {IDLE, LOAD, START, BIT, STOP, GAP} state_t;

  state_t        state, state_d;
  logic [QW-1:0] qcnt, qcnt_d;
  logic [1:0]    qtr, qtr_d;
  logic [SW-1:0] slot, slot_d;
  logic [FW-1:0] shreg, shreg_d;
  logic [IW-1:0] idx, idx_d;
  logic [6:0]    hreg, hreg_d;
  logic [8:0]    hdata, hdata_d;
  logic          abort, abort_d;
  logic          init_done_d, nack_d, scl_d, rel_d, busy_d, ready_d;
  logic          tick, ack_slot, accept;
  logic [15:0]   entry;

  // Init table entry as {reg[6:0], data[8:0]}
  function automatic logic [15:0] init_entry(input logic [IW-1:0] i);
    case (i)
      4'd0:    return {7'h0F, 9'h000};
      4'd1:    return {7'h00, 9'h017};
      4'd2:    return {7'h01, 9'h017};
      4'd3:    return {7'h02, 9'h079};
      4'd4:    return {7'h03, 9'h079};
      4'd5:    return {7'h04, 9'h012};
      4'd6:    return {7'h05, 9'h000};
      4'd7:    return {7'h06, 9'h000};
      4'd8:    return {7'h07, 9'h002};
      4'd9:    return {7'h08, 9'h000};
      default: return {7'h09, 9'h001};
    endcase
  endfunction

  assign tick     = (qcnt == QTR_MAX);
  assign ack_slot = (slot == SW'(8)) || (slot == SW'(17)) || (slot == LAST_SLOT);
  assign accept   = host_wr_en_i && host_ready_o;
  assign entry    = init_done_o ? {hreg, hdata} : init_entry(idx);
  assign sda_o    = 1'b0;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d     = state;
    qcnt_d      = tick ? '0 : qcnt + QW'(1);
    qtr_d       = tick ? qtr + 2'd1 : qtr;
    slot_d      = slot;
    shreg_d     = shreg;
    idx_d       = idx;
    hreg_d      = hreg;
    hdata_d     = hdata;
    abort_d     = abort;
    init_done_d = init_done_o || !INIT_EN;
    nack_d      = nack_clr_i ? 1'b0 : nack_o;
    scl_d       = 1'b1;
    rel_d       = 1'b1;

    case (state)
      IDLE: begin
        if (INIT_EN && !init_done_o) begin
          state_d = LOAD;
        end else if (accept) begin
          hreg_d  = host_reg_i;
          hdata_d = host_data_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // ACK slots are shifted out as 1 so SDA is released for the slave
        shreg_d = {DEV_ADDR, 1'b0, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
        qcnt_d  = '0;
        qtr_d   = 2'd0;
        slot_d  = '0;
        abort_d = 1'b0;
        state_d = START;
      end
      START: begin
        if (tick && qtr == 2'd3) state_d = BIT;
      end
      BIT: begin
        if (tick) begin
          if (qtr == 2'd2 && ack_slot && sda_i) begin
            nack_d  = 1'b1;
            abort_d = 1'b1;
          end
          if (qtr == 2'd3) begin
            if (abort || slot == LAST_SLOT) begin
              state_d = STOP;
            end else begin
              slot_d  = slot + SW'(1);
              shreg_d = {shreg[FW-2:0], 1'b1};
            end
          end
        end
      end
      STOP: begin
        if (tick && qtr == 2'd3) state_d = GAP;
      end
      GAP: begin
        if (tick && qtr == 2'd3) begin
          if (!init_done_o && idx != LAST_IDX) begin
            idx_d   = idx + IW'(1);
            state_d = LOAD;
          end else begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin levels follow the next phase so the registered pins line up with state
    case (state_d)
      START: begin
        scl_d = (qtr_d != 2'd3);
        rel_d = (qtr_d == 2'd0);
      end
      BIT: begin
        scl_d = qtr_d[1];
        rel_d = shreg_d[FW-1];
      end
      STOP: begin
        scl_d = (qtr_d != 2'd0);
        rel_d = qtr_d[1];
      end
      default: begin
        scl_d = 1'b1;
        rel_d = 1'b1;
      end
    endcase

    busy_d  = (state_d == START) || (state_d == BIT) || (state_d == STOP) || (state_d == GAP);
    ready_d = (state_d == IDLE) && init_done_d;
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state         <= IDLE;
      qcnt          <= '0;
      qtr           <= 2'd0;
      slot          <= '0;
      shreg         <= '1;
      idx           <= '0;
      hreg          <= '0;
      hdata         <= '0;
      abort         <= 1'b0;
      init_done_o   <= 1'b0;
      nack_o        <= 1'b0;
      scl_o         <= 1'b1;
      release_sda_o <= 1'b1;
      busy_o        <= 1'b0;
      host_ready_o  <= 1'b0;
    end else begin
      state         <= state_d;
      qcnt          <= qcnt_d;
      qtr           <= qtr_d;
      slot          <= slot_d;
      shreg         <= shreg_d;
      idx           <= idx_d;
      hreg          <= hreg_d;
      hdata         <= hdata_d;
      abort         <= abort_d;
      init_done_o   <= init_done_d;
      nack_o        <= nack_d;
      scl_o         <= scl_d;
      release_sda_o <= rel_d;
      busy_o        <= busy_d;
      host_ready_o  <= ready_d;
    end
  end

endmodule

// File: tb/tb_syn_wm8731_i2c_cfg.sv
// Directed bench for syn_wm8731_i2c_cfg: bus-level I2C slave/decoder on the main
// instance, plus an INIT_EN=0 instance with no slave attached.
module tb_syn_wm8731_i2c_cfg;
  localparam int unsigned QTR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (init enabled, slave model attached)
  logic       rst_n, wr_en, nack_clr;
  logic [6:0] hreg;
  logic [8:0] hdata;
  logic       ready, busy, done, nack, scl, sda_drv, rel, sda_line;
  logic       ack_drive = 1'b0;
  assign sda_line = rel & ~ack_drive;

  syn_wm8731_i2c_cfg #(.QTR_DIV(QTR), .DEV_ADDR(7'h1A), .INIT_EN(1'b1)) dut (
    .clk_ir(clk), .rst_il(rst_n), .host_wr_en_i(wr_en), .host_reg_i(hreg),
    .host_data_i(hdata), .host_ready_o(ready), .busy_o(busy), .init_done_o(done),
    .nack_o(nack), .nack_clr_i(nack_clr), .scl_o(scl), .sda_o(sda_drv),
    .release_sda_o(rel), .sda_i(sda_line));

  // Init-disabled instance; SDA only has a pull-up, so every ACK slot reads NACK
  logic       rst0_n, wr_en0, nack_clr0;
  logic [6:0] hreg0;
  logic [8:0] hdata0;
  logic       ready0, busy0, done0, nack0, scl0, sda_drv0, rel0;

  syn_wm8731_i2c_cfg #(.QTR_DIV(QTR), .DEV_ADDR(7'h1A), .INIT_EN(1'b0)) dut0 (
    .clk_ir(clk), .rst_il(rst0_n), .host_wr_en_i(wr_en0), .host_reg_i(hreg0),
    .host_data_i(hdata0), .host_ready_o(ready0), .busy_o(busy0), .init_done_o(done0),
    .nack_o(nack0), .nack_clr_i(nack_clr0), .scl_o(scl0), .sda_o(sda_drv0),
    .release_sda_o(rel0), .sda_i(rel0));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [23:0] bytes;
    int          t_start;
    int          t_stop;
  } frame_t;

  frame_t      frames[$];
  int          cyc = 0;
  logic        prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0;
  int          mon_bit = 0, mon_byte = 0, t_start = 0;
  logic [7:0]  sh = '0;
  logic [23:0] acc = '0;
  int          nack_frame = -1, nack_byte = -1;
  logic        act0 = 1'b0;
  logic [2:0]  tr [0:1023];

  function automatic frame_t fr(input int i);
    frame_t f = '{default: 0};
    if (i < frames.size()) f = frames[i];
    return f;
  endfunction

  // Bus decoder and ACKing slave; sampled on the falling clock edge
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (rst0_n && !scl0) act0 = 1'b1;
      if (!rst_n) begin
        in_frame  = 1'b0;
        ack_drive = 1'b0;
      end else if (scl && prev_scl && prev_sda && !sda_line) begin
        in_frame = 1'b1; mon_bit = 0; mon_byte = 0; acc = '0; t_start = cyc;
      end else if (in_frame && scl && prev_scl && !prev_sda && sda_line) begin
        frames.push_back('{n: mon_byte, bytes: acc, t_start: t_start, t_stop: cyc});
        in_frame = 1'b0;
      end else if (in_frame && scl && !prev_scl) begin
        if (mon_bit < 8) begin
          sh = {sh[6:0], sda_line};
          mon_bit++;
          if (mon_bit == 8) acc = {acc[15:0], sh};
        end else begin
          mon_bit = 0;
          mon_byte++;
        end
      end else if (in_frame && !scl && prev_scl) begin
        ack_drive = (mon_bit == 8) && !(frames.size() == nack_frame && mon_byte == nack_byte);
      end
      prev_scl = scl;
      prev_sda = sda_line;
    end
  end

  // Host write; tr[k] holds {scl, release, busy} at the k-th falling edge after acceptance
  task automatic host_write(input logic [6:0] r, input logic [8:0] d, input int pulse_k,
                            output int low);
    @(negedge clk);
    wr_en = 1'b1; hreg = r; hdata = d;
    low = 0;
    for (int k = 1; k < 1000; k++) begin
      @(negedge clk);
      wr_en = (k == pulse_k);
      if (k == pulse_k) hreg = 7'h55;
      tr[k] = {scl, rel, busy};
      if (ready) break;
      low++;
    end
    wr_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin : stim
    int n, nf, low;
    rst_n = 1'b0; rst0_n = 1'b0; wr_en = 1'b0; nack_clr = 1'b0; hreg = '0; hdata = '0;
    wr_en0 = 1'b0; nack_clr0 = 1'b0; hreg0 = '0; hdata0 = '0;
    repeat (3) @(negedge clk);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_rel", 32'(rel), 32'd1);
    check("rst_sda", 32'(sda_drv), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nack", 32'(nack), 32'd0);
    check("rst0_done", 32'(done0), 32'd0);

    // Release; init-disabled instance is ready after one clock
    rst_n = 1'b1; rst0_n = 1'b1;
    @(posedge clk); #1;
    check("noinit_done", 32'(done0), 32'd1);
    check("noinit_ready", 32'(ready0), 32'd1);

    // Init time counted from the first clock after release
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk); n++; #1;
    end
    check("init_cycles", 32'(n), 32'(11 * 481));
    check("init_frames", 32'(frames.size()), 32'd11);
    check("f0_bytes", 32'(fr(0).bytes), 32'h341E00);
    check("f0_n", 32'(fr(0).n), 32'd3);
    check("f10_bytes", 32'(fr(10).bytes), 32'h341201);
    check("f_spacing", 32'(fr(1).t_start - fr(0).t_start), 32'd481);
    check("f_len", 32'(fr(0).t_stop - fr(0).t_start), 32'd452);
    check("init_nack", 32'(nack), 32'd0);
    check("init_ready", 32'(ready), 32'd1);
    check("noinit_quiet", 32'(act0), 32'd0);

    // Host write reg 04 data 012
    nf = frames.size();
    host_write(7'h04, 9'h012, -1, low);
    check("w1_low", 32'(low), 32'd481);
    check("w1_count", 32'(frames.size()), 32'(nf + 1));
    check("w1_bytes", 32'(fr(nf).bytes), 32'h340812);
    check("start_q0", 32'(tr[2][2:1]), 32'b11);
    check("start_q1", 32'(tr[6][2:1]), 32'b10);
    check("start_q2", 32'(tr[10][2:1]), 32'b10);
    check("start_q3", 32'(tr[14][2:1]), 32'b00);
    check("bit0_q0", 32'(tr[18][2:1]), 32'b00);
    check("bit0_q2", 32'(tr[26][2:1]), 32'b10);
    check("bit2_q0", 32'(tr[50][2:1]), 32'b01);
    check("bit2_q2", 32'(tr[58][2:1]), 32'b11);
    check("stop_q0", 32'(tr[450][2:1]), 32'b00);
    check("stop_q1", 32'(tr[454][2:1]), 32'b10);
    check("stop_q2", 32'(tr[458][2:1]), 32'b11);
    check("stop_q3", 32'(tr[462][2:1]), 32'b11);
    check("busy_load", 32'(tr[1][0]), 32'd0);
    check("busy_start", 32'(tr[2][0]), 32'd1);
    check("busy_gap", 32'(tr[481][0]), 32'd1);

    // Host write reg 02 data 17F with an ignored request while busy
    host_write(7'h02, 9'h17F, 100, low);
    check("w2_low", 32'(low), 32'd481);
    check("w2_bytes", 32'(fr(nf + 1).bytes), 32'h34057F);
    repeat (600) @(negedge clk);
    check("w2_no_extra", 32'(frames.size()), 32'(nf + 2));
    check("w2_ready", 32'(ready), 32'd1);

    // Slave NACKs byte1 of init entry 3
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    frames.delete(); nack_frame = 3; nack_byte = 1;
    rst_n = 1'b1;
    wait_done("nk_done");
    check("nk_nack", 32'(nack), 32'd1);
    check("nk_frames", 32'(frames.size()), 32'd11);
    check("nk_f3_n", 32'(fr(3).n), 32'd2);
    check("nk_f3_bytes", 32'(fr(3).bytes), 32'h003404);
    check("nk_f3_len", 32'(fr(3).t_stop - fr(3).t_start), 32'd308);
    check("nk_f4_bytes", 32'(fr(4).bytes), 32'h340679);
    nack_frame = -1; nack_byte = -1;
    @(negedge clk); nack_clr = 1'b1;
    @(negedge clk); nack_clr = 1'b0;
    check("nk_clear", 32'(nack), 32'd0);

    // Async reset during bit 5 of byte1
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    frames.delete();
    rst_n = 1'b1;
    n = 0;
    while (!(in_frame && mon_byte == 1 && mon_bit == 5 && !scl) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("rr_reach", 32'(n < 3000), 32'd1);
    #1;
    check("rr_pre_scl", 32'(scl), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rr_scl", 32'(scl), 32'd1);
    check("rr_rel", 32'(rel), 32'd1);
    check("rr_busy", 32'(busy), 32'd0);
    @(negedge clk); frames.delete();
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    while (frames.size() < 1 && n < 1000) begin
      @(negedge clk); n++;
    end
    check("rr_f0_bytes", 32'(fr(0).bytes), 32'h341E00);
    check("rr_f0_n", 32'(fr(0).n), 32'd3);

    // INIT_EN=0 instance: NACK sample and clear on the same clock, set wins
    @(negedge clk);
    wr_en0 = 1'b1; hreg0 = 7'h04; hdata0 = 9'h000;
    for (int k = 1; k <= 158; k++) begin
      @(negedge clk);
      wr_en0 = 1'b0;
      if (k == 157) begin
        check("sim_pre", 32'(nack0), 32'd0);
        nack_clr0 = 1'b1;
      end
      if (k == 158) begin
        nack_clr0 = 1'b0;
        check("sim_set_wins", 32'(nack0), 32'd1);
      end
    end
    @(negedge clk); nack_clr0 = 1'b1;
    @(negedge clk); nack_clr0 = 1'b0;
    check("sim_clear", 32'(nack0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
